// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared types and constants for the GPU DMA read/write engines.
package painterengine_gpu_dma_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_ROUTING       = 3'd0,
    ST_PARAM_CHECK   = 3'd1,
    ST_CALC_ADDRESS  = 3'd2,
    ST_ADDRESS_WRITE = 3'd3,
    ST_DATA_WRITE    = 3'd4,
    ST_RESPONSE_WAIT = 3'd5,
    ST_DONE          = 3'd6,
    ST_ERROR         = 3'd7
  } dma_state_e;

  typedef enum logic [2:0] {
    ERR_OK                = 3'd0,
    ERR_ROUTER            = 3'd1,
    ERR_ADDRESS           = 3'd2,
    ERR_ADDR_RESP_TIMEOUT = 3'd3,
    ERR_DATA_TIMEOUT      = 3'd4,
    ERR_PROTOCOL          = 3'd5,
    ERR_RESP_TIMEOUT      = 3'd6
  } dma_err_e;

  localparam logic [2:0] AXI_SIZE_WORD        = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } dma_aw_t;

endpackage

// File: rtl/painterengine_gpu_dma_burst_calc.sv
// Beats available before the next MAX_BURST-word window boundary, clipped to the words left.
module painterengine_gpu_dma_burst_calc
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 256
) (
  input  logic [$clog2(MAX_BURST)-1:0] i_addr_window,
  input  logic [31:0]                  i_offset,
  input  logic [31:0]                  i_length,
  output logic [$clog2(MAX_BURST):0]   o_burstlen_c
);

  localparam int unsigned WIN_W = $clog2(MAX_BURST);
  localparam int unsigned BL_W  = WIN_W + 1;

  logic [WIN_W-1:0] unalign;
  logic [BL_W-1:0]  aligned;
  logic [31:0]      remaining;

  always_comb begin
    unalign      = i_addr_window + i_offset[WIN_W-1:0];
    aligned      = BL_W'(MAX_BURST) - BL_W'(unalign);
    remaining    = i_length - i_offset;
    o_burstlen_c = (remaining < 32'(aligned)) ? remaining[BL_W-1:0] : aligned;
  end

endmodule

// File: rtl/painterengine_gpu_dma_writer.sv
// AXI4 write-master DMA: streams one selected source lane to memory in
// window-aligned INCR bursts, then reports done or a typed error.
module painterengine_gpu_dma_writer
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int unsigned TIMEOUT_BIT = 18,
  parameter int unsigned MAX_BURST   = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  output logic         o_wire_done,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_data,
  input  logic [3:0]   i_wire_data_valid,
  output logic [3:0]   o_wire_data_next,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_AWID,
  output logic [31:0]  o_wire_M_AXI_AWADDR,
  output logic [7:0]   o_wire_M_AXI_AWLEN,
  output logic [2:0]   o_wire_M_AXI_AWSIZE,
  output logic [1:0]   o_wire_M_AXI_AWBURST,
  output logic         o_wire_M_AXI_AWLOCK,
  output logic [3:0]   o_wire_M_AXI_AWCACHE,
  output logic [2:0]   o_wire_M_AXI_AWPROT,
  output logic [3:0]   o_wire_M_AXI_AWQOS,
  output logic         o_wire_M_AXI_AWVALID,
  input  logic         i_wire_M_AXI_AWREADY,
  output logic [31:0]  o_wire_M_AXI_WDATA,
  output logic [3:0]   o_wire_M_AXI_WSTRB,
  output logic         o_wire_M_AXI_WLAST,
  output logic         o_wire_M_AXI_WVALID,
  input  logic         i_wire_M_AXI_WREADY,
  input  logic         i_wire_M_AXI_BID,
  input  logic [1:0]   i_wire_M_AXI_BRESP,
  input  logic         i_wire_M_AXI_BVALID,
  output logic         o_wire_M_AXI_BREADY
);

  localparam int unsigned WIN_W = $clog2(MAX_BURST);
  localparam int unsigned BL_W  = WIN_W + 1;
  localparam int unsigned TMO_W = TIMEOUT_BIT + 1;

  dma_state_e       state_q, state_d;
  dma_err_e         err_q, err_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      offset_q, offset_d;
  logic [BL_W-1:0]  burstlen_q, burstlen_d;
  logic [BL_W-1:0]  beat_q, beat_d;
  dma_aw_t          aw_q, aw_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [BL_W-1:0]  burstlen_c;
  logic             wvalid_c, wlast_c, w_hs_c, aw_hs_c;
  logic             route_ok_c;
  logic [1:0]       route_idx_c;
  logic             unused_bid;

  assign unused_bid = i_wire_M_AXI_BID;

  painterengine_gpu_dma_burst_calc #(
    .MAX_BURST(MAX_BURST)
  ) u_burst_calc (
    .i_addr_window(addr_q[WIN_W+1:2]),
    .i_offset     (offset_q),
    .i_length     (len_q),
    .o_burstlen_c (burstlen_c)
  );

  // Handshake qualifiers; W-channel valid tracks the selected source lane directly.
  assign wvalid_c = (state_q == ST_DATA_WRITE) & i_wire_data_valid[idx_q];
  assign wlast_c  = (state_q == ST_DATA_WRITE) & (beat_q == (burstlen_q - BL_W'(1)));
  assign w_hs_c   = wvalid_c & i_wire_M_AXI_WREADY;
  assign aw_hs_c  = (state_q == ST_ADDRESS_WRITE) & i_wire_M_AXI_AWREADY;

  assign o_wire_M_AXI_AWID    = 1'b0;
  assign o_wire_M_AXI_AWADDR  = aw_q.addr;
  assign o_wire_M_AXI_AWLEN   = aw_q.len;
  assign o_wire_M_AXI_AWSIZE  = AXI_SIZE_WORD;
  assign o_wire_M_AXI_AWBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_AWLOCK  = 1'b0;
  assign o_wire_M_AXI_AWCACHE = AXI_CACHE_MODIFIABLE;
  assign o_wire_M_AXI_AWPROT  = 3'b000;
  assign o_wire_M_AXI_AWQOS   = 4'b0000;
  assign o_wire_M_AXI_AWVALID = (state_q == ST_ADDRESS_WRITE);
  assign o_wire_M_AXI_WDATA   = i_wire_data[{idx_q, 5'b00000} +: 32];
  assign o_wire_M_AXI_WSTRB   = 4'hF;
  assign o_wire_M_AXI_WLAST   = wlast_c;
  assign o_wire_M_AXI_WVALID  = wvalid_c;
  assign o_wire_M_AXI_BREADY  = (state_q == ST_RESPONSE_WAIT);
  assign o_wire_done          = (state_q == ST_DONE);
  assign o_wire_error         = (state_q == ST_ERROR);
  assign o_wire_error_type    = err_q;
  assign o_wire_data_next     = w_hs_c ? (4'b0001 << idx_q) : 4'b0000;

  always_comb begin
    route_ok_c  = 1'b1;
    route_idx_c = 2'd0;
    case (i_wire_router)
      4'b0001: route_idx_c = 2'd0;
      4'b0010: route_idx_c = 2'd1;
      4'b0100: route_idx_c = 2'd2;
      4'b1000: route_idx_c = 2'd3;
      default: route_ok_c  = 1'b0;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    offset_d   = offset_q;
    burstlen_d = burstlen_q;
    beat_d     = beat_q;
    aw_d       = aw_q;
    tmo_d      = '0;

    case (state_q)
      ST_ROUTING: begin
        if (route_ok_c) begin
          idx_d   = route_idx_c;
          addr_d  = i_wire_address[{route_idx_c, 5'b00000} +: 32];
          len_d   = i_wire_length[{route_idx_c, 5'b00000} +: 32];
          state_d = ST_PARAM_CHECK;
        end else begin
          err_d   = ERR_ROUTER;
          state_d = ST_ERROR;
        end
      end
      ST_PARAM_CHECK: begin
        if ((addr_q[1:0] != 2'b00) || (len_q == 32'd0)) begin
          err_d   = ERR_ADDRESS;
          state_d = ST_ERROR;
        end else begin
          offset_d = 32'd0;
          state_d  = ST_CALC_ADDRESS;
        end
      end
      ST_CALC_ADDRESS: begin
        burstlen_d = burstlen_c;
        aw_d.addr  = addr_q + {offset_q[29:0], 2'b00};
        aw_d.len   = 8'(burstlen_c - BL_W'(1));
        state_d    = ST_ADDRESS_WRITE;
      end
      ST_ADDRESS_WRITE: begin
        if (aw_hs_c) begin
          beat_d  = '0;
          state_d = ST_DATA_WRITE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DATA_WRITE: begin
        if (w_hs_c) begin
          beat_d = beat_q + BL_W'(1);
          if (wlast_c) state_d = ST_RESPONSE_WAIT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RESPONSE_WAIT: begin
        if (i_wire_M_AXI_BVALID) begin
          if (i_wire_M_AXI_BRESP != 2'b00) begin
            err_d   = ERR_PROTOCOL;
            state_d = ST_ERROR;
          end else begin
            offset_d = offset_q + 32'(burstlen_q);
            state_d  = (offset_d >= len_q) ? ST_DONE : ST_CALC_ADDRESS;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: ;
    endcase

    // A stalled handshake overrides whatever step the FSM would have taken.
    if (tmo_q[TIMEOUT_BIT]) begin
      tmo_d   = '0;
      state_d = ST_ERROR;
      case (state_q)
        ST_ADDRESS_WRITE: err_d = ERR_ADDR_RESP_TIMEOUT;
        ST_DATA_WRITE:    err_d = ERR_DATA_TIMEOUT;
        default:          err_d = ERR_RESP_TIMEOUT;
      endcase
    end
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q    <= ST_ROUTING;
      err_q      <= ERR_OK;
      idx_q      <= 2'd0;
      addr_q     <= 32'd0;
      len_q      <= 32'd0;
      offset_q   <= 32'd0;
      burstlen_q <= '0;
      beat_q     <= '0;
      aw_q       <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      burstlen_q <= burstlen_d;
      beat_q     <= beat_d;
      aw_q       <= aw_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_writer.sv
// Scoreboard bench for the GPU DMA writer: stimulus pushes expected AW/W/status, a monitor pops and compares.
module tb_painterengine_gpu_dma_writer;

  localparam int unsigned TB_TIMEOUT_BIT = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done, error;
  logic [2:0]   etype;
  logic [127:0] address, length, data;
  logic [3:0]   router_i, data_valid, data_next;
  logic         awid, awlock, awvalid, awready;
  logic [31:0]  awaddr, wdata;
  logic [7:0]   awlen;
  logic [2:0]   awsize, awprot;
  logic [1:0]   awburst, bresp;
  logic [3:0]   awcache, awqos, wstrb;
  logic         wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_fail = 0;

  logic [39:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];
  logic [4:0]  exp_st_q[$];
  logic [1:0]  b_resp_q[$];

  int          lane = 0;
  logic [31:0] src_words[16];
  int          src_n = 0, src_idx = 0, gap_cnt = 0, cyc = 0, pop_cnt = 0;
  bit          toggle_valid = 0, wready_gap = 0, aw_en = 1;
  bit          armed = 0, final_seen = 0;

  initial forever #5 clk = ~clk;

  painterengine_gpu_dma_writer #(.TIMEOUT_BIT(TB_TIMEOUT_BIT), .MAX_BURST(256)) dut (
    .i_wire_clock(clk), .i_wire_reset(rst), .o_wire_done(done),
    .i_wire_address(address), .i_wire_length(length), .i_wire_router(router_i),
    .i_wire_data(data), .i_wire_data_valid(data_valid), .o_wire_data_next(data_next),
    .o_wire_error(error), .o_wire_error_type(etype),
    .o_wire_M_AXI_AWID(awid), .o_wire_M_AXI_AWADDR(awaddr), .o_wire_M_AXI_AWLEN(awlen),
    .o_wire_M_AXI_AWSIZE(awsize), .o_wire_M_AXI_AWBURST(awburst), .o_wire_M_AXI_AWLOCK(awlock),
    .o_wire_M_AXI_AWCACHE(awcache), .o_wire_M_AXI_AWPROT(awprot), .o_wire_M_AXI_AWQOS(awqos),
    .o_wire_M_AXI_AWVALID(awvalid), .i_wire_M_AXI_AWREADY(awready),
    .o_wire_M_AXI_WDATA(wdata), .o_wire_M_AXI_WSTRB(wstrb), .o_wire_M_AXI_WLAST(wlast),
    .o_wire_M_AXI_WVALID(wvalid), .i_wire_M_AXI_WREADY(wready),
    .i_wire_M_AXI_BID(1'b0), .i_wire_M_AXI_BRESP(bresp), .i_wire_M_AXI_BVALID(bvalid),
    .o_wire_M_AXI_BREADY(bready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event not expected / not seen", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake or final status.
  initial forever begin
    logic [39:0] ea;
    logic [32:0] ew;
    logic [4:0]  es;
    bit          hs;
    @(negedge clk);
    if (!rst) begin
      if (awvalid && awready) begin
        if (exp_aw_q.size() == 0) fail_now("unexpected AW");
        else begin
          ea = exp_aw_q.pop_front();
          check("AW addr/len", {awaddr, awlen}, ea);
          check("AW fixed fields", {awid, awsize, awburst, awlock, awcache, awprot, awqos},
                {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'b000, 4'b0000});
        end
      end
      hs = wvalid && wready;
      if (hs) begin
        if (exp_w_q.size() == 0) fail_now("unexpected W");
        else begin
          ew = exp_w_q.pop_front();
          check("W data/last", {wdata, wlast}, ew);
          check("W strobe", wstrb, 4'hF);
        end
      end
      if (hs || data_next != 4'b0000) begin
        check("data_next", data_next, hs ? 4'(1 << lane) : 4'b0000);
        pop_cnt++;
      end
      if (armed && (done || error)) begin
        armed = 0;
        final_seen = 1;
        if (exp_st_q.size() == 0) fail_now("unexpected final status");
        else begin
          es = exp_st_q.pop_front();
          check("final done/error/type", {done, error, etype}, es);
        end
      end
    end
  end

  // Source lanes and AWREADY, updated just after each rising edge.
  initial forever begin
    bit pop_s;
    bit wr;
    @(negedge clk);
    pop_s = data_next[lane];
    @(posedge clk);
    #1;
    if (pop_s) begin
      src_idx++;
      gap_cnt = 0;
    end
    cyc++;
    wr = !(wready_gap && (src_idx == 2 || src_idx == 3) && gap_cnt < 3);
    if (!wr) gap_cnt++;
    wready = wr;
    for (int ch = 0; ch < 4; ch++) begin
      data[ch*32 +: 32] = 32'hDEAD_0000 + 32'(ch);
      data_valid[ch] = 1'b1;
    end
    data[lane*32 +: 32] = (src_idx < src_n) ? src_words[src_idx] : 32'h0;
    data_valid[lane] = (src_idx < src_n) && (!toggle_valid || cyc[0]);
    awready = aw_en;
  end

  // Write-response responder: one queued BRESP per RESPONSE_WAIT visit.
  initial forever begin
    @(posedge clk);
    #1;
    bvalid = 1'b0;
    bresp = 2'b00;
    if (!rst && bready && b_resp_q.size() > 0) begin
      bvalid = 1'b1;
      bresp = b_resp_q.pop_front();
    end
  end

  task automatic setup(input logic [3:0] rt, input logic [31:0] addr, input logic [31:0] len, input int ln);
    @(posedge clk);
    #2;
    rst = 1'b1;
    armed = 0;
    final_seen = 0;
    router_i = rt;
    address = {4{32'hFFFF_FFF1}};
    length = '0;
    address[ln*32 +: 32] = addr;
    length[ln*32 +: 32] = len;
    lane = ln;
    src_idx = 0;
    src_n = 0;
    gap_cnt = 0;
    pop_cnt = 0;
    toggle_valid = 0;
    wready_gap = 0;
    aw_en = 1;
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_st_q.delete();
    b_resp_q.delete();
    @(posedge clk);
    #2;
    check("outputs in reset", {done, error, etype, awvalid, wvalid, bready, data_next}, 13'd0);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    armed = 1;
  endtask

  task automatic finish_xfer(input int budget, input int exp_pops);
    for (int i = 0; i < budget && !final_seen; i++) @(negedge clk);
    if (!final_seen) fail_now("final status timeout");
    repeat (6) @(negedge clk);
    check("leftover AW", exp_aw_q.size(), 0);
    check("leftover W", exp_w_q.size(), 0);
    check("sticky end state", {done | error, awvalid, wvalid}, 3'b100);
    check("pop count", pop_cnt, exp_pops);
  endtask

  task automatic load_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) src_words[i] = base + 32'(i);
    src_n = n;
  endtask

  initial begin
    bit seen;
    address = '0; length = '0; router_i = 4'b0; data = '0; data_valid = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;

    // Single 4-beat burst on lane 1.
    setup(4'b0010, 32'h1000, 32'd4, 1);
    load_words(32'hA0, 4);
    exp_aw_q.push_back({32'h1000, 8'd3});
    for (int i = 0; i < 4; i++) exp_w_q.push_back({32'hA0 + 32'(i), i == 3});
    b_resp_q.push_back(2'b00);
    exp_st_q.push_back({1'b1, 1'b0, 3'd0});
    release_rst();
    finish_xfer(200, 4);

    // 1 KB boundary split: 2 beats then 8 beats.
    setup(4'b0001, 32'h13F8, 32'd10, 0);
    load_words(32'h100, 10);
    exp_aw_q.push_back({32'h13F8, 8'd1});
    exp_aw_q.push_back({32'h1400, 8'd7});
    for (int i = 0; i < 10; i++) exp_w_q.push_back({32'h100 + 32'(i), (i == 1) || (i == 9)});
    b_resp_q.push_back(2'b00);
    b_resp_q.push_back(2'b00);
    exp_st_q.push_back({1'b1, 1'b0, 3'd0});
    release_rst();
    finish_xfer(300, 10);

    // Router and parameter errors.
    setup(4'b0011, 32'h1000, 32'd4, 0);
    exp_st_q.push_back({1'b0, 1'b1, 3'd1});
    release_rst();
    finish_xfer(50, 0);

    setup(4'b0001, 32'h1002, 32'd8, 0);
    exp_st_q.push_back({1'b0, 1'b1, 3'd2});
    release_rst();
    finish_xfer(50, 0);

    setup(4'b0001, 32'h1000, 32'd0, 0);
    exp_st_q.push_back({1'b0, 1'b1, 3'd2});
    release_rst();
    finish_xfer(50, 0);

    // Lane 3, toggling source valid and WREADY gaps on beats 3-4.
    setup(4'b1000, 32'h2000, 32'd8, 3);
    load_words(32'hC0, 8);
    toggle_valid = 1;
    wready_gap = 1;
    exp_aw_q.push_back({32'h2000, 8'd7});
    for (int i = 0; i < 8; i++) exp_w_q.push_back({32'hC0 + 32'(i), i == 7});
    b_resp_q.push_back(2'b00);
    exp_st_q.push_back({1'b1, 1'b0, 3'd0});
    release_rst();
    finish_xfer(300, 8);

    // SLVERR on first of two bursts: no second AW.
    setup(4'b0100, 32'h33F0, 32'd8, 2);
    load_words(32'h200, 8);
    exp_aw_q.push_back({32'h33F0, 8'd3});
    for (int i = 0; i < 4; i++) exp_w_q.push_back({32'h200 + 32'(i), i == 3});
    b_resp_q.push_back(2'b10);
    exp_st_q.push_back({1'b0, 1'b1, 3'd5});
    release_rst();
    finish_xfer(300, 4);

    // AWREADY stuck low.
    setup(4'b0001, 32'h1000, 32'd4, 0);
    load_words(32'h300, 4);
    aw_en = 0;
    exp_st_q.push_back({1'b0, 1'b1, 3'd3});
    release_rst();
    finish_xfer(1000, 0);

    // Source never valid.
    setup(4'b0001, 32'h1000, 32'd4, 0);
    exp_aw_q.push_back({32'h1000, 8'd3});
    exp_st_q.push_back({1'b0, 1'b1, 3'd4});
    release_rst();
    finish_xfer(1000, 0);

    // BVALID never arrives.
    setup(4'b0001, 32'h1000, 32'd4, 0);
    load_words(32'h400, 4);
    exp_aw_q.push_back({32'h1000, 8'd3});
    for (int i = 0; i < 4; i++) exp_w_q.push_back({32'h400 + 32'(i), i == 3});
    exp_st_q.push_back({1'b0, 1'b1, 3'd6});
    release_rst();
    finish_xfer(1000, 4);

    // Reset asserted in the middle of a data burst.
    setup(4'b0001, 32'h1000, 32'd8, 0);
    load_words(32'h500, 8);
    exp_aw_q.push_back({32'h1000, 8'd7});
    for (int i = 0; i < 8; i++) exp_w_q.push_back({32'h500 + 32'(i), i == 7});
    release_rst();
    armed = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = wvalid;
    end
    check("reached data phase", seen, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("outputs after mid-burst reset", {done, error, etype, awvalid, wvalid, bready, data_next}, 13'd0);
    exp_aw_q.delete();
    exp_w_q.delete();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/painterengine_gpu_dma_writer.md
Name: painterengine_gpu_dma_writer

Overview:
AXI4 write-master DMA for the GPU IP, the write-direction counterpart of the GPU DMA read engine. It accepts a one-hot router select among four source channels and latches that channel's word address and word length. It streams the channel's 32-bit data into memory as INCR bursts that never cross a 1 KB (256-beat) boundary, then reports done or a typed error.

Parameters:
TIMEOUT_BIT, 18, index of the timeout counter bit whose assertion is fatal (counter width TIMEOUT_BIT+1; 262144-cycle stall limit).
MAX_BURST, 256, maximum beats per burst and alignment window in beats.

Ports:
i_wire_clock  input  1  sole clock, rising edge.
i_wire_reset  input  1  asynchronous, active-high reset.
o_wire_done  output  1  high while state==DONE.
i_wire_address  input  128  four 32-bit byte addresses; channel n at [n*32+:32].
i_wire_length  input  128  four 32-bit lengths in 32-bit words.
i_wire_router  input  4  one-hot channel select, sampled only in ROUTING.
i_wire_data  input  128  four 32-bit source data lanes.
i_wire_data_valid  input  4  per-lane source valid.
o_wire_data_next  output  4  per-lane pop strobe (beat consumed this cycle).
o_wire_error  output  1  high while state==ERROR.
o_wire_error_type  output  3  error code.
o_wire_M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWLOCK/AWCACHE/AWPROT/AWQOS/AWVALID  output  1/32/8/3/2/1/4/3/4/1  AXI write address.
i_wire_M_AXI_AWREADY  input  1.
o_wire_M_AXI_WDATA/WSTRB/WLAST/WVALID  output  32/4/1/1  AXI write data.
i_wire_M_AXI_WREADY  input  1.
i_wire_M_AXI_BID/BRESP/BVALID  input  1/2/1  AXI write response.
o_wire_M_AXI_BREADY  output  1.

Behaviour:
- Constants: AWID=0, AWSIZE=3'b010, AWBURST=INCR, AWLOCK=0, AWCACHE=4'b0010, AWPROT=0, AWQOS=0, WSTRB=4'hF.
- Reset (async): state=ROUTING, all counters/registers 0, error_type=OK. AWVALID, WVALID, BREADY, done, error and data_next all 0.
- States (3-bit): ROUTING, PARAM_CHECK, CALC_ADDRESS, ADDRESS_WRITE, DATA_WRITE, RESPONSE_WAIT, DONE, ERROR.
- ROUTING: router 1/2/4/8 latches address, length and index 0..3, then goes to PARAM_CHECK. Any other value (including 0) goes to ERROR with ROUTER_ERROR.
- PARAM_CHECK: address[1:0]!=0 or length==0 goes to ERROR with ADDRESS_ERROR. Otherwise offset=0 and the FSM goes to CALC_ADDRESS.
- CALC_ADDRESS (1 cycle):
  - unalign = (address[9:2]+offset[7:0]) mod 256, 8-bit.
  - aligned = 256-unalign, 9-bit.
  - remaining = length-offset, 32-bit.
  - burstlen = min(aligned, remaining), 9-bit.
  - Next state is ADDRESS_WRITE.
- ADDRESS_WRITE:
  - AWADDR = address+offset*4 and AWLEN = burstlen-1, both registered.
  - AWVALID is held until the AWREADY handshake, then drops the next cycle; beat counter clears; FSM goes to DATA_WRITE.
- DATA_WRITE:
  - WDATA is the latched lane and WVALID = data_valid[index].
  - WLAST = (beat==burstlen-1).
  - data_next[index] = WVALID & WREADY; other lanes are 0, and all lanes are 0 outside DATA_WRITE.
  - Each handshake increments beat. On the WLAST handshake the FSM goes to RESPONSE_WAIT.
  - WVALID never asserts before the AW handshake completes.
- RESPONSE_WAIT:
  - BREADY=1.
  - On BVALID with BRESP!=0, go to ERROR with PROTOCOL_ERROR.
  - Otherwise offset += burstlen. If offset>=length go to DONE, else go to CALC_ADDRESS.
- Error codes: 0 OK, 1 ROUTER_ERROR, 2 ADDRESS_ERROR, 3 ADDRESS_RESPONSE_TIMEOUT, 4 DATA_TIMEOUT, 5 PROTOCOL_ERROR, 6 RESPONSE_TIMEOUT.
- Timeout counter:
  - Increments every cycle spent waiting in ADDRESS_WRITE, DATA_WRITE (no handshake) or RESPONSE_WAIT.
  - Clears on every handshake and on every state change.
  - When bit TIMEOUT_BIT is set, the FSM goes to ERROR with the code for the current state (3, 4 or 6); this takes priority over the FSM step.
- DONE and ERROR are sticky until reset. error_type holds its value and no AXI valid is asserted.
- Router, address and length changes after ROUTING are ignored.
- Reset mid-burst drops all valids immediately. The AXI interconnect shares this reset, so the abandoned transaction is accepted behaviour.

Decomposition:
- Package painterengine_gpu_dma_pkg holds:
  - the FSM state encodings;
  - the error-type codes, shared with the read engine;
  - the AXI constant fields (SIZE, BURST, CACHE).
- One natural sub-module: painterengine_gpu_dma_burst_calc, a combinational unaligned/aligned/min computation from address, offset and length. The read engine can reuse it.

Test Plan:
- router=2, addr=0x1000, len=4, WREADY/AWREADY always 1, lane1 data 0xA0..0xA3 -> one burst AWADDR=0x1000, AWLEN=3, WLAST on beat 4, BRESP=0 -> done=1, error_type=0, data_next=4'b0010 exactly 4 cycles.
- router=1, addr=0x13F8, len=10 -> two bursts: AWADDR 0x13F8/AWLEN 1, then AWADDR 0x1400/AWLEN 7; done after second B.
- router=4'b0011 -> error=1, type=1 with no AWVALID; separately addr=0x1002, len=8 -> type=2; separately len=0 -> type=2.
- Burst of 8 with lane valid toggling every other cycle and WREADY low on beats 3-4 -> exactly 8 handshakes, data order preserved, data_next only on handshakes.
- BRESP=2'b10 on first burst of a 2-burst transfer -> error type=5, no second AWVALID.
- AWREADY held 0 -> error type=3 after 262144 waiting cycles; WVALID held 0 -> type=4; BVALID held 0 -> type=6. Assert reset mid-DATA_WRITE -> all outputs return to reset values the same cycle.
